// File: rtl/ula_sequencer_if.sv
// ula_sequencer_if -- operand/result bus between the issue sequencer and the
// combinational ULA.
//   alu_a, alu_b  32  registered operands (sequencer -> ULA)
//   alu_opcode     5  registered opcode   (sequencer -> ULA)
//   alu_out       32  combinational result (ULA -> sequencer)
// master = sequencer side, slave = ULA side.
interface ula_sequencer_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_out;

  modport master (output alu_a, output alu_b, output alu_opcode, input alu_out);
  modport slave  (input alu_a, input alu_b, input alu_opcode, output alu_out);
endinterface

// File: rtl/ula_sequencer.sv
// ula_sequencer -- four-state issue/writeback sequencer in front of the ULA.
// Accepts one instruction in IDLE, reads ra/rb from a 16x32 register file,
// drives the ULA, writes alu_out back to rd and keeps the N/Z/C/V flags.
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   instr_valid/instr_ready  instruction handshake (ready only in IDLE)
//   instr[31:15]             {opcode, rd, ra, rb}; [14:0] ignored
//   ext_we/waddr/wdata       register preload, honoured in IDLE only
//   ula                      operand/opcode out, alu_out in
//   result, flags            last written-back value, {N,Z,C,V}
//   done, err                one-cycle pulses in WB (err: illegal opcode)
//   dbg_raddr/dbg_rdata      combinational register read, r0 reads 0
module ula_sequencer (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            ext_we,
  input  logic [3:0]      ext_waddr,
  input  logic [31:0]     ext_wdata,
  ula_sequencer_if.master ula,
  output logic [31:0]     result,
  output logic [3:0]      flags,
  output logic            done,
  output logic            err,
  input  logic [3:0]      dbg_raddr,
  output logic [31:0]     dbg_rdata
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [4:0] op;
    logic [3:0] rd;
    logic [3:0] ra;
    logic [3:0] rb;
  } req_t;

  state_t      state, state_nxt;
  req_t        req, instr_req;
  logic [31:0] regs [16];
  logic [31:0] bp;
  logic        arith, c_new, v_new;
  logic        unused_bits;

  // 00010, 00111 and 01010..01111 are holes in the opcode map.
  function automatic logic illegal_op(input logic [4:0] op);
    return (op == 5'b00010) || (op == 5'b00111) ||
           (op[4:3] == 2'b01 && op[2:1] != 2'b00);
  endfunction

  assign instr_req   = req_t'(instr[31:15]);
  assign unused_bits = ^instr[14:0];
  // r0 is cleared by reset and never written, so it always reads 0.
  assign dbg_rdata   = regs[dbg_raddr];

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: state_nxt = WB;
      WB: begin
        done      = 1'b1;
        err       = illegal_op(req.op);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Effective addend seen by the ULA adder; the carry/overflow rules below
  // only need its sign bit together with a[31] and r[31].
  always_comb begin
    bp    = '0;
    arith = 1'b0;
    case (req.op)
      5'b00000, 5'b00001: begin bp = ula.alu_b;    arith = 1'b1; end
      5'b00011:           begin bp = '0;           arith = 1'b1; end
      5'b00100, 5'b00101: begin bp = ~ula.alu_b;   arith = 1'b1; end
      5'b00110:           begin bp = 32'hFFFFFFFF; arith = 1'b1; end
      default: ;
    endcase
  end

  assign c_new = (ula.alu_a[31] & bp[31]) |
                 ((ula.alu_a[31] | bp[31]) & ~ula.alu_out[31]);
  assign v_new = (ula.alu_a[31] == bp[31]) && (ula.alu_out[31] != ula.alu_a[31]);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req            <= '0;
      ula.alu_a      <= '0;
      ula.alu_b      <= '0;
      ula.alu_opcode <= '0;
      result         <= '0;
      flags          <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Preload lands at the accept edge, so READ sees it.
          if (ext_we && ext_waddr != 4'd0) regs[ext_waddr] <= ext_wdata;
          if (instr_valid) req <= instr_req;
        end
        READ: begin
          ula.alu_a      <= regs[req.ra];
          ula.alu_b      <= regs[req.rb];
          ula.alu_opcode <= req.op;
        end
        EXEC: begin
          if (!illegal_op(req.op)) begin
            result <= ula.alu_out;
            if (req.rd != 4'd0) regs[req.rd] <= ula.alu_out;
            flags[3] <= ula.alu_out[31];
            flags[2] <= (ula.alu_out == 32'd0);
            if (arith) begin
              flags[1] <= c_new;
              flags[0] <= v_new;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_sequencer.sv
module tb_ula_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        ext_we = 1'b0;
  logic [3:0]  ext_waddr = '0;
  logic [31:0] ext_wdata = '0;
  logic [3:0]  dbg_raddr = '0;
  logic        instr_ready, done, err;
  logic [31:0] result, dbg_rdata;
  logic [3:0]  flags;

  int checks = 0;
  int failures = 0;

  ula_sequencer_if bus();

  // Behavioural ULA used as the environment the sequencer drives.
  function automatic logic [31:0] ula_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a + b + 32'd1;
      5'd3:  return a + 32'd1;
      5'd4:  return a + ~b;
      5'd5:  return a - b;
      5'd6:  return a - 32'd1;
      5'd8:  return a << b[4:0];
      5'd9:  return 32'(sa >>> b[4:0]);
      5'd16: return a & b;
      5'd17: return a | b;
      5'd18: return a ^ b;
      5'd19: return a;
      5'd20: return b;
      5'd21: return ~a;
      5'd22: return 32'd0;
      5'd23: return 32'hFFFFFFFF;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign bus.alu_out = ula_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

  ula_sequencer dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .ula(bus), .result(result), .flags(flags), .done(done), .err(err),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_load(input logic [3:0] a, input logic [31:0] d);
    ext_we = 1'b1; ext_waddr = a; ext_wdata = d;
    step();
    ext_we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [31:0] d);
    dbg_raddr = a;
    #1;
    d = dbg_rdata;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rd,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb, 15'h5A5A};
  endfunction

  // Full handshake plus cycle-accurate done/err/ready timing.
  task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                       input logic [3:0] rb, input bit hold, input bit exp_err,
                       input string nm);
    instr = mk(op, rd, ra, rb);
    instr_valid = 1'b1;
    step();                                   // accept edge
    ext_we = 1'b0;
    if (!hold) instr_valid = 1'b0;
    chk({nm, " ready c1"}, 32'(instr_ready), 32'd0);
    chk({nm, " done c1"}, 32'(done), 32'd0);
    step();
    chk({nm, " done c2"}, 32'(done), 32'd0);
    step();
    chk({nm, " done c3"}, 32'(done), 32'd1);
    chk({nm, " err c3"}, 32'(err), 32'(exp_err));
    instr_valid = 1'b0;
    step();
    chk({nm, " ready c4"}, 32'(instr_ready), 32'd1);
    chk({nm, " done c4"}, 32'(done), 32'd0);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_regs [16];
  logic [31:0] m_result;
  logic [3:0]  m_flags;

  function automatic bit m_illegal(input logic [4:0] op);
    int o;
    o = int'(op);
    return (o == 2) || (o == 7) || (o >= 10 && o <= 15);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_result = '0;
    m_flags = '0;
  endtask

  task automatic m_exec(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                        input logic [3:0] rb);
    logic [31:0] a, b, r, bp;
    logic [32:0] sum;
    longint s;
    int cin;
    bit ar;
    if (m_illegal(op)) return;
    a = m_regs[ra]; b = m_regs[rb];
    r = ula_fn(op, a, b);
    m_result = r;
    if (rd != 4'd0) m_regs[rd] = r;
    m_flags[3] = r[31];
    m_flags[2] = (r == 32'd0);
    ar = 1'b1; bp = b; cin = 0;
    case (int'(op))
      0: begin bp = b;            cin = 0; end
      1: begin bp = b;            cin = 1; end
      3: begin bp = 32'd0;        cin = 1; end
      4: begin bp = ~b;           cin = 0; end
      5: begin bp = ~b;           cin = 1; end
      6: begin bp = 32'hFFFFFFFF; cin = 0; end
      default: ar = 1'b0;
    endcase
    if (ar) begin
      sum = {1'b0, a} + {1'b0, bp} + 33'(cin);
      s = longint'($signed(a)) + longint'($signed(bp)) + longint'(cin);
      m_flags[1] = sum[32];
      m_flags[0] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd, ra, rb;
    logic [31:0] exp_val;
    logic [31:0] exp_res;
    logic [3:0]  exp_flags;
    bit          exp_err;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] d;
    vt[0]  = '{5'b00000, 4'd3,  4'd1,  4'd2,  32'h80000000, 32'h80000000, 4'b1001, 1'b0};
    vt[1]  = '{5'b10010, 4'd0,  4'd1,  4'd1,  32'h00000000, 32'h00000000, 4'b0101, 1'b0};
    vt[2]  = '{5'b00101, 4'd6,  4'd4,  4'd5,  32'h00000000, 32'h00000000, 4'b0110, 1'b0};
    vt[3]  = '{5'b00000, 4'd9,  4'd10, 4'd11, 32'h00000000, 32'h00000000, 4'b0110, 1'b0};
    vt[4]  = '{5'b00010, 4'd7,  4'd1,  4'd2,  32'h00001234, 32'h00000000, 4'b0110, 1'b1};
    vt[5]  = '{5'b00011, 4'd12, 4'd13, 4'd0,  32'h80000000, 32'h80000000, 4'b1001, 1'b0};
    vt[6]  = '{5'b00110, 4'd12, 4'd0,  4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vt[7]  = '{5'b00100, 4'd14, 4'd13, 4'd2,  32'h7FFFFFFD, 32'h7FFFFFFD, 4'b0010, 1'b0};
    vt[8]  = '{5'b01000, 4'd15, 4'd2,  4'd2,  32'h00000002, 32'h00000002, 4'b0010, 1'b0};
    vt[9]  = '{5'b00001, 4'd1,  4'd2,  4'd2,  32'h00000003, 32'h00000003, 4'b0000, 1'b0};
    vt[10] = '{5'b01001, 4'd5,  4'd3,  4'd2,  32'hC0000000, 32'hC0000000, 4'b1000, 1'b0};
    vt[11] = '{5'b01111, 4'd3,  4'd1,  4'd2,  32'h80000000, 32'hC0000000, 4'b1000, 1'b1};

    // Reset sequencing
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("rst flags", 32'(flags), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst err", 32'(err), 32'd0);
    chk("rst ready", 32'(instr_ready), 32'd1);
    chk("rst alu_a", bus.alu_a, 32'd0);
    chk("rst alu_op", 32'(bus.alu_opcode), 32'd0);
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), d);
      chk($sformatf("rst r%0d", i), d, 32'd0);
    end

    // Preloads, including an ignored write to r0
    ext_load(4'd0, 32'hDEADBEEF);
    ext_load(4'd1, 32'h7FFFFFFF);
    ext_load(4'd2, 32'd1);
    ext_load(4'd4, 32'd5);
    ext_load(4'd5, 32'd5);
    ext_load(4'd7, 32'h1234);
    ext_load(4'd10, 32'hFFFFFFFF);
    ext_load(4'd11, 32'd1);
    ext_load(4'd13, 32'h7FFFFFFF);
    peek(4'd0, d);
    chk("ext r0 ignored", d, 32'd0);

    for (int i = 0; i < 12; i++) begin
      issue(vt[i].op, vt[i].rd, vt[i].ra, vt[i].rb, 1'b0, vt[i].exp_err,
            $sformatf("vec%0d", i));
      chk($sformatf("vec%0d result", i), result, vt[i].exp_res);
      chk($sformatf("vec%0d flags", i), 32'(flags), 32'(vt[i].exp_flags));
      peek(vt[i].rd, d);
      chk($sformatf("vec%0d rd", i), d, vt[i].exp_val);
    end

    // Preload coincident with accept: READ must see the new r8
    ext_we = 1'b1; ext_waddr = 4'd8; ext_wdata = 32'd10;
    issue(5'b00000, 4'd9, 4'd8, 4'd2, 1'b0, 1'b0, "ext+accept");
    chk("ext+accept result", result, 32'd11);

    // Preload attempted while busy is ignored
    instr = mk(5'b10011, 4'd10, 4'd9, 4'd0);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    ext_we = 1'b1; ext_waddr = 4'd2; ext_wdata = 32'hBAD0BAD0;
    step(); step();
    chk("busy ext done c3", 32'(done), 32'd1);
    ext_we = 1'b0;
    step();
    peek(4'd2, d);
    chk("busy ext r2", d, 32'd1);
    peek(4'd10, d);
    chk("pass r10", d, 32'd11);

    // valid held high through READ/EXEC: exactly one completion
    issue(5'b00000, 4'd11, 4'd2, 4'd2, 1'b1, 1'b0, "hold");
    for (int i = 0; i < 4; i++) begin
      chk("hold no 2nd done", 32'(done), 32'd0);
      step();
    end
    peek(4'd11, d);
    chk("hold r11", d, 32'd2);

    // Reset during WB: done drops on the next cycle
    instr = mk(5'b00000, 4'd12, 4'd2, 4'd2);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("wbrst done c3", 32'(done), 32'd1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("wbrst done drop", 32'(done), 32'd0);

    // Reset during EXEC: no writeback, no done
    ext_load(4'd1, 32'd7);
    ext_load(4'd2, 32'd8);
    instr = mk(5'b00000, 4'd8, 4'd1, 4'd2);
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("exrst done", 32'(done), 32'd0);
    chk("exrst result", result, 32'd0);
    chk("exrst flags", 32'(flags), 32'd0);
    chk("exrst ready", 32'(instr_ready), 32'd1);
    peek(4'd8, d);
    chk("exrst r8", d, 32'd0);

    // Randomized run against the reference model
    m_reset();
    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      logic [3:0] rd, ra, rb, wa;
      logic [31:0] wd;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        wa = 4'($urandom_range(0, 15));
        wd = rval();
        ext_load(wa, wd);
        if (wa != 4'd0) m_regs[wa] = wd;
      end
      op = 5'($urandom_range(0, 31));
      rd = 4'($urandom_range(0, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      issue(op, rd, ra, rb, 1'b0, m_illegal(op), $sformatf("rnd%0d", n));
      m_exec(op, rd, ra, rb);
      chk($sformatf("rnd%0d result", n), result, m_result);
      chk($sformatf("rnd%0d flags", n), 32'(flags), 32'(m_flags));
      peek(rd, d);
      chk($sformatf("rnd%0d rd", n), d, m_regs[rd]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_sequencer.md
# ula_sequencer

Multi-cycle issue/writeback sequencer that drives the ULA: it accepts one instruction at a time, reads two operands from an internal 16×32 register file, and presents opcode and operands to the combinational ULA. It then captures the ULA result, writes it back, and maintains the processor's N/Z/C/V flag register. It is the initiator side of the ULA interface and sits between instruction fetch and the ULA in the Lapido datapath.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit opcode, 4-bit register index.
- Reset is synchronous and active-low, on a single clock.
- clk  in  1  sole clock; all state changes on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  high only in IDLE; a transfer occurs when valid & ready.
- instr  in  32  fields:
  - [31:27] opcode
  - [26:23] rd
  - [22:19] ra
  - [18:15] rb
  - [14:0] ignored
- ext_we / ext_waddr / ext_wdata  in  1/4/32  register preload port; honoured only in IDLE.
- alu_a, alu_b  out  32  registered operands to ULA A, B.
- alu_opcode  out  5  registered opcode to ULA.
- alu_out  in  32  ULA result, combinational from alu_a/alu_b/alu_opcode.
- result  out  32  last written-back value.
- flags  out  4  {N,Z,C,V}.
- done  out  1  one-cycle pulse per completed instruction.
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
- dbg_raddr / dbg_rdata  in 4 / out 32  combinational register read for the bench; r0 reads 0.

## Operation
- FSM states: IDLE → READ → EXEC → WB → IDLE. No stalls; every accepted instruction takes exactly 4 states.
- IDLE: instr_ready=1. On valid&ready, latch opcode/rd/ra/rb and go to READ.
- READ: load alu_a←R[ra], alu_b←R[rb], alu_opcode←opcode. Go to EXEC.
- EXEC: alu_out settles. At the closing edge:
  - result←alu_out
  - R[rd]←alu_out
  - flags updated
  - go to WB
- WB: done=1, err as classified. Go to IDLE.
- Register r0 reads 0 and ignores writes from both instructions and ext port. Flags still update when rd=0.
- Legal opcodes:
  - add 00000, addinc 00001, inca 00011
  - subdec 00100, sub 00101, deca 00110
  - lsl 01000, asr 01001
  - 10000–11111 (logic/pass/zeros/ones)
- Illegal opcodes: 00010, 00111, 01010–01111. They pass through READ/EXEC, but perform no register write, no flag change and no result update. err=1 in WB.
- Flag rules, with a=alu_a, r=alu_out and b' the effective addend:
  - Z = (r==0); N = r[31], for every legal opcode.
  - Add family, b': add/addinc b'=alu_b; inca b'=0.
  - Sub family, b': sub/subdec b'=~alu_b; deca b'=32'hFFFFFFFF.
  - Add and sub families: C = (a31&b'31)|((a31|b'31)&~r31). V = (a31==b'31)&(r31!=a31). For sub, C=1 means no borrow.
  - Shift and logic opcodes: C and V held.
- ext port write in IDLE takes effect at that edge. If it coincides with an instruction accept, the write still occurs and READ sees the new value. ext_we outside IDLE is ignored.
- instr_valid outside IDLE is ignored. No buffering.

## Timing
- Reset (reset_n=0 at an edge):
  - state=IDLE
  - all registers R[1..15]=0
  - alu_a=alu_b=0, alu_opcode=0
  - result=0, flags=0
  - done=err=0
  - instr_ready=1 from the first cycle after reset
- Accept at edge 0 → READ in cycle 1 → EXEC in cycle 2 → writeback at edge 3 → done/err high during cycle 3 → instr_ready high in cycle 4.
- Throughput is one instruction per 4 cycles. An instruction reading the previous rd sees the written value; no hazard exists.
- Reset asserted in READ/EXEC: abort with no writeback and no flag change. Asserted in WB: done drops the next cycle.
- ULA path from alu_a/alu_b/alu_opcode to alu_out must close within one clock (EXEC).

## Test plan
- Reset sequencing:
  - Stimulus: hold reset_n=0 for 2 cycles, then release.
  - Response: flags=0, result=0, done=0, instr_ready=1. dbg_rdata=0 for all indices.
- Overflow add:
  - Stimulus: ext-load r1=32'h7FFFFFFF, r2=1; issue add rd=3, ra=1, rb=2.
  - Response: done in cycle 3; R3=32'h80000000; flags N=1, Z=0, C=0, V=1.
- Equal sub and carry:
  - Stimulus: r4=r5=5; issue sub rd=6, ra=4, rb=5.
  - Response: R6=0, N=0, Z=1, C=1, V=0.
  - Stimulus: then add 32'hFFFFFFFF+1.
  - Response: Z=1, C=1.
- Flag hold and r0:
  - Stimulus: after the overflow add, issue xor rd=0 with ra=rb.
  - Response: R0 stays 0, Z=1, N=0; C and V retain 0 and 1.
- Illegal opcode:
  - Stimulus: issue opcode 00010 with rd=7.
  - Response: err=done=1 in cycle 3; R7, result and flags unchanged.
- Reset mid-operation and busy:
  - Stimulus: assert reset_n=0 during EXEC of add rd=8.
  - Response: R8=0, no done pulse.
  - Stimulus: drive instr_valid high during READ.
  - Response: no second accept.
